// File: rtl/icache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : icache_fill_ctrl
// Brief   : Instruction-cache prefetch window, miss-status table and fill port.
// Revision: 1.0 - initial release
// ============================================================================
module icache_fill_ctrl #(
   parameter int NUM_MSHR       = 4,
   parameter int PREFETCH_LINES = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] fetch_pc,
   input  logic        redirect,
   input  logic        prefetch_pc_is_in_cache,
   output logic [31:0] prefetch_pc_check,
   input  logic        icache_grant,
   output logic [1:0]  proc2mem_command,
   output logic [31:0] proc2mem_addr,
   input  logic [3:0]  mem2proc_response,
   input  logic [63:0] mem2proc_data,
   input  logic [3:0]  mem2proc_tag,
   output logic        write_enable,
   output logic [31:0] write_addr,
   output logic [63:0] write_data
);

   localparam logic [1:0]  c_BUS_NONE = 2'd0;
   localparam logic [1:0]  c_BUS_LOAD = 2'd1;
   localparam int          c_IDX_W    = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;
   localparam logic [31:0] c_WINDOW   = 32'(8 * PREFETCH_LINES);

   logic [31:0]         r_pf_addr;
   logic [NUM_MSHR-1:0] r_valid;
   logic [31:0]         r_addr [NUM_MSHR];
   logic [3:0]          r_tag  [NUM_MSHR];

   logic [31:0]         w_fetch_block;
   logic [31:0]         w_offset;
   logic                w_in_window;
   logic                w_pf_in_mshr;
   logic                w_free_any;
   logic [c_IDX_W-1:0]  w_free_idx;
   logic                w_fill;
   logic [c_IDX_W-1:0]  w_fill_idx;
   logic                w_issue;
   logic                w_accept;

   always_comb begin
      w_fetch_block = {fetch_pc[31:3], 3'b000};
      w_offset      = r_pf_addr - w_fetch_block;
      w_in_window   = (w_offset < c_WINDOW);
      w_pf_in_mshr  = 1'b0;
      w_free_any    = 1'b0;
      w_free_idx    = '0;
      w_fill        = 1'b0;
      w_fill_idx    = '0;
      // Descending scan so the lowest-index free entry is the one that sticks.
      for (int i = NUM_MSHR - 1; i >= 0; i--) begin
         if (r_valid[i] && (r_addr[i] == r_pf_addr)) begin
            w_pf_in_mshr = 1'b1;
         end
         if (!r_valid[i]) begin
            w_free_any = 1'b1;
            w_free_idx = c_IDX_W'(i);
         end
         if (r_valid[i] && (mem2proc_tag != 4'd0) && (r_tag[i] == mem2proc_tag)) begin
            w_fill     = 1'b1;
            w_fill_idx = c_IDX_W'(i);
         end
      end
      w_issue = !reset && !redirect && w_in_window && !prefetch_pc_is_in_cache &&
                !w_pf_in_mshr && w_free_any && icache_grant;
      w_accept         = w_issue && (mem2proc_response != 4'd0);
      proc2mem_command = w_issue ? c_BUS_LOAD : c_BUS_NONE;
      proc2mem_addr    = w_issue ? r_pf_addr : 32'd0;
   end

   assign prefetch_pc_check = r_pf_addr;

   // Free and allocate read the registered valid vector, so an entry freed at
   // this edge cannot be reallocated until the following cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pf_addr    <= 32'd0;
         r_valid      <= '0;
         write_enable <= 1'b0;
         write_addr   <= 32'd0;
         write_data   <= 64'd0;
      end else begin
         if (redirect || !w_in_window) begin
            r_pf_addr <= w_fetch_block;
         end else if (prefetch_pc_is_in_cache || w_pf_in_mshr || w_accept) begin
            r_pf_addr <= r_pf_addr + 32'd8;
         end
         write_enable <= w_fill;
         if (w_fill) begin
            write_addr          <= r_addr[w_fill_idx];
            write_data          <= mem2proc_data;
            r_valid[w_fill_idx] <= 1'b0;
         end
         if (w_accept) begin
            r_valid[w_free_idx] <= 1'b1;
            r_addr[w_free_idx]  <= r_pf_addr;
            r_tag[w_free_idx]   <= mem2proc_response;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_icache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_icache_fill_ctrl
// Brief   : Directed and randomized bench for icache_fill_ctrl with a queue model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_icache_fill_ctrl;

   localparam int NUM_MSHR       = 4;
   localparam int PREFETCH_LINES = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] fetch_pc;
   logic        redirect;
   logic        in_cache;
   logic [31:0] pc_check;
   logic        grant;
   logic [1:0]  cmd;
   logic [31:0] addr;
   logic [3:0]  resp;
   logic [63:0] mdata;
   logic [3:0]  mtag;
   logic        we;
   logic [31:0] wa;
   logic [63:0] wd;

   icache_fill_ctrl #(.NUM_MSHR(NUM_MSHR), .PREFETCH_LINES(PREFETCH_LINES)) dut (
      .clock                   (clock),
      .reset                   (reset),
      .fetch_pc                (fetch_pc),
      .redirect                (redirect),
      .prefetch_pc_is_in_cache (in_cache),
      .prefetch_pc_check       (pc_check),
      .icache_grant            (grant),
      .proc2mem_command        (cmd),
      .proc2mem_addr           (addr),
      .mem2proc_response       (resp),
      .mem2proc_data           (mdata),
      .mem2proc_tag            (mtag),
      .write_enable            (we),
      .write_addr              (wa),
      .write_data              (wd)
   );

   always #5 clock = ~clock;

   // Outstanding requests are an unordered set of {line, tag}; slot index is invisible.
   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  tag;
   } pend_t;

   pend_t       m_q[$];
   logic [31:0] m_pf = 32'd0;
   logic        m_we = 1'b0;
   logic [31:0] m_wa = 32'd0;
   logic [63:0] m_wd = 64'd0;
   logic [31:0] m_fb;
   logic        m_inwin, m_inq, m_issue;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic comb_phase();
      #1;
      m_fb    = {fetch_pc[31:3], 3'b000};
      m_inwin = (m_pf - m_fb) < 32'(8 * PREFETCH_LINES);
      m_inq   = 1'b0;
      foreach (m_q[i]) if (m_q[i].addr == m_pf) m_inq = 1'b1;
      m_issue = !reset && !redirect && m_inwin && !in_cache && !m_inq &&
                (m_q.size() < NUM_MSHR) && grant;
      chk("cmd", 64'(cmd), m_issue ? 64'd1 : 64'd0);
      chk("req_addr", 64'(addr), m_issue ? 64'(m_pf) : 64'd0);
      chk("pf_check", 64'(pc_check), 64'(m_pf));
   endtask

   task automatic edge_phase();
      int hit;
      @(posedge clock);
      if (reset) begin
         m_q.delete();
         m_pf = 32'd0;
         m_we = 1'b0;
         m_wa = 32'd0;
         m_wd = 64'd0;
      end else begin
         hit = -1;
         if (mtag != 4'd0) foreach (m_q[i]) if (m_q[i].tag == mtag) hit = i;
         m_we = (hit >= 0);
         if (hit >= 0) begin
            m_wa = m_q[hit].addr;
            m_wd = mdata;
            m_q.delete(hit);
         end
         if (m_issue && resp != 4'd0) m_q.push_back('{addr: m_pf, tag: resp});
         if (redirect || !m_inwin) m_pf = m_fb;
         else if (in_cache || m_inq || (m_issue && resp != 4'd0)) m_pf = m_pf + 32'd8;
      end
      #1;
      chk("write_enable", 64'(we), 64'(m_we));
      chk("write_addr", 64'(wa), 64'(m_wa));
      chk("write_data", wd, m_wd);
      @(negedge clock);
   endtask

   task automatic cycle();
      comb_phase();
      edge_phase();
   endtask

   task automatic cyc_req(input logic [31:0] a);
      comb_phase();
      chk("dir_cmd_load", 64'(cmd), 64'd1);
      chk("dir_req_addr", 64'(addr), 64'(a));
      edge_phase();
   endtask

   task automatic cyc_none();
      comb_phase();
      chk("dir_cmd_none", 64'(cmd), 64'd0);
      chk("dir_addr_zero", 64'(addr), 64'd0);
      edge_phase();
   endtask

   function automatic logic [3:0] unused_tag();
      logic [3:0] t;
      bit         used;
      t = 4'($urandom_range(1, 15));
      for (int k = 0; k < 15; k++) begin
         used = 1'b0;
         foreach (m_q[i]) if (m_q[i].tag == t) used = 1'b1;
         if (!used) return t;
         t = (t == 4'd15) ? 4'd1 : t + 4'd1;
      end
      return 4'd0;
   endfunction

   initial begin
      int r;
      reset    = 1'b1;
      fetch_pc = 32'h100;
      redirect = 1'b0;
      in_cache = 1'b0;
      grant    = 1'b1;
      resp     = 4'd1;
      mdata    = 64'd0;
      mtag     = 4'd0;
      @(posedge clock);
      @(negedge clock);
      cyc_none();
      chk("reset_we", 64'(we), 64'd0);
      chk("reset_pf", 64'(pc_check), 64'd0);

      // Cold start: four requests fill the window and the table.
      reset = 1'b0; redirect = 1'b1; resp = 4'd0;
      cyc_none();
      redirect = 1'b0;
      for (int k = 0; k < 4; k++) begin
         resp = 4'(k + 1);
         cyc_req(32'h100 + 32'(8 * k));
      end
      resp = 4'd5;
      cyc_none();

      // Fill of tag 2, then drain the rest with memory rejecting everything.
      resp = 4'd0; mtag = 4'd2; mdata = 64'hDEADBEEF_00C0FFEE;
      cycle();
      chk("fill_we", 64'(we), 64'd1);
      chk("fill_addr", 64'(wa), 64'h108);
      chk("fill_data", wd, 64'hDEADBEEF_00C0FFEE);
      mtag = 4'd0;
      cycle();
      chk("fill_we_drop", 64'(we), 64'd0);
      mtag = 4'd1; cycle();
      mtag = 4'd3; cycle();
      mtag = 4'd4; cycle();
      mtag = 4'd0;

      // Rejected requests retry at the same address; a cache hit skips the line.
      fetch_pc = 32'h200; redirect = 1'b1;
      cyc_none();
      redirect = 1'b0;
      for (int k = 0; k < 3; k++) cyc_req(32'h200);
      in_cache = 1'b1;
      cyc_none();
      chk("hit_skip_pf", 64'(pc_check), 64'h208);
      in_cache = 1'b0;

      // Redirect with two requests in flight.
      resp = 4'd5; cyc_req(32'h208);
      resp = 4'd6; cyc_req(32'h210);
      fetch_pc = 32'h400; redirect = 1'b1; resp = 4'd0;
      cyc_none();
      redirect = 1'b0; resp = 4'd7;
      cyc_req(32'h400);
      grant = 1'b0; resp = 4'd0;
      mtag = 4'd5; mdata = {$urandom, $urandom}; cycle();
      chk("old_fill_5", 64'(wa), 64'h208);
      mtag = 4'd6; mdata = {$urandom, $urandom}; cycle();
      chk("old_fill_6", 64'(wa), 64'h210);
      mtag = 4'd7; mdata = {$urandom, $urandom}; cycle();
      chk("new_fill_7", 64'(wa), 64'h400);
      mtag = 4'd0;

      // Address wrap and a foreign tag.
      fetch_pc = 32'hFFFF_FFF8; redirect = 1'b1; grant = 1'b1;
      cyc_none();
      redirect = 1'b0;
      resp = 4'd8; cyc_req(32'hFFFF_FFF8);
      resp = 4'd9; cyc_req(32'h0000_0000);
      grant = 1'b0; resp = 4'd0; mtag = 4'd7;
      cycle();
      chk("foreign_tag_we", 64'(we), 64'd0);
      mtag = 4'd8; cycle();
      mtag = 4'd9; cycle();
      mtag = 4'd0;

      // Reset with three requests outstanding; late tags must not write.
      fetch_pc = 32'h800; redirect = 1'b1; grant = 1'b1;
      cyc_none();
      redirect = 1'b0;
      for (int k = 0; k < 3; k++) begin
         resp = 4'(k + 1);
         cyc_req(32'h800 + 32'(8 * k));
      end
      reset = 1'b1; resp = 4'd4;
      cyc_none();
      chk("midrst_we", 64'(we), 64'd0);
      chk("midrst_wa", 64'(wa), 64'd0);
      chk("midrst_wd", wd, 64'd0);
      chk("midrst_pf", 64'(pc_check), 64'd0);
      reset = 1'b0; grant = 1'b0; resp = 4'd0;
      for (int k = 0; k < 3; k++) begin
         mtag = 4'(k + 1);
         cycle();
         chk("stale_tag_we", 64'(we), 64'd0);
      end
      mtag = 4'd0;

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         reset    = ($urandom_range(0, 99) == 0);
         redirect = 1'b0;
         r = $urandom_range(0, 99);
         if (r < 8) begin
            redirect = 1'b1;
            fetch_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFE0 + 32'($urandom_range(0, 31))
                                                  : 32'($urandom);
         end else if (r < 40) begin
            fetch_pc = fetch_pc + 32'd4;
         end
         in_cache = ($urandom_range(0, 3) == 0);
         grant    = ($urandom_range(0, 3) != 0);
         resp     = ($urandom_range(0, 3) == 0) ? 4'd0 : unused_tag();
         r = $urandom_range(0, 99);
         if (r < 40 && m_q.size() > 0) mtag = m_q[$urandom_range(0, m_q.size() - 1)].tag;
         else if (r < 50)               mtag = unused_tag();
         else                           mtag = 4'd0;
         mdata = {$urandom, $urandom};
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/icache_fill_ctrl.md
# icache_fill_ctrl

Instruction-cache fill and prefetch controller. It is the writer side of the instruction cache: it keeps a window of sequential 8-byte lines ahead of the fetch PC, probes the cache through the prefetch-check port, and issues `BUS_LOAD` requests to memory for lines that are missing. It tracks outstanding requests in a small miss-status table and drives the cache write port (`write_enable`/`write_addr`/`write_data`) when tagged memory responses return. It sits between fetch, the instruction cache and the shared memory bus arbiter.

## Interface
- `NUM_MSHR`, 4: outstanding request entries (1..8).
- `PREFETCH_LINES`, 4: window size in 8-byte lines, counted from the fetch block.

- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `fetch_pc`  in  32  current fetch PC.
- `redirect`  in  1  non-sequential PC change this cycle.
- `prefetch_pc_is_in_cache`  in  1  cache hit result for `prefetch_pc_check`, combinational, same cycle.
- `prefetch_pc_check`  out  32  line address being probed (equals `pf_addr`).
- `icache_grant`  in  1  arbiter grants the bus to icache this cycle.
- `proc2mem_command`  out  2  0=`BUS_NONE`, 1=`BUS_LOAD`; combinational.
- `proc2mem_addr`  out  32  request address, always 8-byte aligned.
- `mem2proc_response`  in  4  nonzero = accepted, value is the transaction tag; 0 = rejected.
- `mem2proc_data`  in  64  returned line data.
- `mem2proc_tag`  in  4  tag of the returning data; 0 = none.
- `write_enable`  out  1  cache fill strobe, registered.
- `write_addr`  out  32  fill line address, registered.
- `write_data`  out  64  fill data, registered; `[31:0]` = word 0, `[63:32]` = word 1.

## Operation
- `fetch_block = {fetch_pc[31:3],3'b0}`. `offset = pf_addr - fetch_block`, computed as a 32-bit unsigned value; modulo wrap is legal. `in_window = offset < 8*PREFETCH_LINES`.
- Pointer update, registered, first matching rule wins:
  - `redirect`, or `!in_window`: `pf_addr <= fetch_block`.
  - The probe is satisfied: `pf_addr <= pf_addr + 8`, 32-bit wrap. The probe is satisfied when `prefetch_pc_is_in_cache`, when `pf_addr` matches a valid MSHR address, or when a request is accepted this cycle.
  - Otherwise `pf_addr` holds.
- Request issue, combinational: `proc2mem_command = BUS_LOAD` and `proc2mem_addr = pf_addr` iff all of the following hold:
  - `!reset`, `!redirect`, `in_window`;
  - `!prefetch_pc_is_in_cache`;
  - no valid MSHR holds `pf_addr`;
  - a free MSHR exists in the registered valid vector;
  - `icache_grant`.
- Otherwise the command is `BUS_NONE` and `proc2mem_addr = 0`.
- Accept: when issuing and `mem2proc_response != 0`, allocate the lowest-index free MSHR with `{valid=1, addr=pf_addr, tag=mem2proc_response}`. A rejected request (response 0) is retried the next cycle and `pf_addr` does not advance.
- Fill: when `mem2proc_tag != 0` and it matches a valid MSHR tag, the next edge does three things:
  - `write_enable <= 1`;
  - `write_addr <= entry.addr`, `write_data <= mem2proc_data`;
  - the entry is invalidated.
- When no tag matches, `write_enable <= 0`; `write_addr` and `write_data` hold. A tag matching no valid entry (a data-cache transaction) is ignored.
- Memory guarantees that outstanding tags are unique, so at most one entry matches.
- `redirect` does not cancel MSHRs. In-flight lines still fill the cache.
- Free and allocate in the same cycle: the entry freed at this edge is not visible as free until the next cycle. Allocation uses a different free entry or waits.
- Full: when all `NUM_MSHR` entries are valid, no request is issued and `pf_addr` holds unless the probe is satisfied.

## Timing
- Reset values:
  - `pf_addr`/`prefetch_pc_check` = 0;
  - all MSHRs invalid;
  - `write_enable` = 0, `write_addr` = 0, `write_data` = 0;
  - `proc2mem_command` = `BUS_NONE`, `proc2mem_addr` = 0 (forced during reset).
- Reset mid-operation clears all MSHRs. Responses arriving afterward match nothing and are ignored.
- Latency from redirect to request: `redirect` in cycle N, `pf_addr` becomes valid at N+1, and the earliest `BUS_LOAD` is in N+1.
- Latency from tag return to fill: tag in cycle M, `write_enable` high in M+1 for exactly one cycle per returned tag.
- Throughput: one request per cycle at most, and one fill per cycle.

## Test plan
- Cold start. After reset, `fetch_pc=0x100`, `redirect` pulse, cache empty, grant=1, responses 1,2,3,4 → `BUS_LOAD` to 0x100, 0x108, 0x110, 0x118 on consecutive cycles. On the 5th cycle the command is `BUS_NONE` (window and MSHRs both full).
- Fill. Return `mem2proc_tag=2` with data `0xDEADBEEF_00C0FFEE` → the next cycle has `write_enable=1`, `write_addr=0x108`, `write_data=0xDEADBEEF_00C0FFEE`. The cycle after, `write_enable=0`.
- Reject and hit skip. `mem2proc_response=0` for 3 cycles → the address is held and re-requested each cycle. `prefetch_pc_is_in_cache=1` at 0x200 → no request, and the pointer advances to 0x208 the next cycle.
- Redirect with outstanding requests. Two MSHRs are pending, then `redirect` to 0x400 → the next request is to 0x400, and the old tags still fill their old addresses.
- Wrap and foreign tag. `fetch_pc=0xFFFF_FFF8` → requests go to 0xFFFF_FFF8 then 0x0000_0000. `mem2proc_tag=7` with no matching entry → `write_enable` stays 0.
- Reset mid-flight. 3 entries outstanding, `reset` for 1 cycle, then the old tags return → no writes occur, and every output is at its reset value during reset.
